// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: issues data-memory accesses, stalls upstream until ack
// or timeout, and registers the regfile write-back port.
module mem_wb_stage #(
    parameter int unsigned DM_LAT_MAX = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic [31:0] mem_npc,
    input  logic [31:0] mem_aluc,
    input  logic [31:0] mem_mul_res,
    input  logic [31:0] mem_dm_wdata,
    input  logic        mem_lw,
    input  logic        mem_jal,
    input  logic        mem_mul,
    input  logic        mem_dm_w_ena,
    input  logic        mem_rf_w_ena,
    input  logic [4:0]  mem_rf_waddr,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ack,
    output logic        mem_stall,
    output logic        wb_rf_w_ena,
    output logic [4:0]  wb_rf_waddr,
    output logic [31:0] wb_rf_wdata,
    output logic        dm_timeout,
    output logic [31:0] retired_cnt
);

    localparam int unsigned CNT_W = $clog2(DM_LAT_MAX + 1);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] w_wait_cnt_nxt;
    logic             w_mem_op;
    logic             w_timeout_hit;
    logic [31:0]      w_wb_data;

    // Reset masks the request so an in-flight access drops immediately.
    assign w_mem_op      = mem_valid & (mem_lw | mem_dm_w_ena) & ~rst;
    assign w_timeout_hit = w_mem_op & ~dm_ack & (r_wait_cnt == CNT_W'(DM_LAT_MAX - 1));

    assign dm_req    = w_mem_op & ((r_state == S_IDLE) | (r_state == S_ACCESS));
    assign dm_we     = dm_req & mem_dm_w_ena;
    assign dm_addr   = dm_req ? mem_aluc : 32'd0;
    assign dm_wdata  = dm_req ? mem_dm_wdata : 32'd0;
    assign mem_stall = dm_req & ~dm_ack & ~w_timeout_hit;

    always_comb begin
        w_wb_data = mem_aluc;
        if (mem_lw)
            w_wb_data = dm_rdata;
        else if (mem_jal)
            w_wb_data = mem_npc;
        else if (mem_mul)
            w_wb_data = mem_mul_res;
    end

    // Wait counter holds the cycles already spent waiting by the current op.
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        case (r_state)
            S_IDLE: begin
                w_wait_cnt_nxt = '0;
                if (mem_stall) begin
                    w_state_nxt    = S_ACCESS;
                    w_wait_cnt_nxt = CNT_W'(1);
                end
            end
            S_ACCESS: begin
                if (mem_stall) begin
                    w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
                end else begin
                    w_state_nxt    = S_IDLE;
                    w_wait_cnt_nxt = '0;
                end
            end
            default: begin
                w_state_nxt    = S_IDLE;
                w_wait_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    // Write-back register: bubble on stall edges, otherwise capture the op.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_rf_w_ena <= 1'b0;
            wb_rf_waddr <= 5'd0;
            wb_rf_wdata <= 32'd0;
            dm_timeout  <= 1'b0;
            retired_cnt <= 32'd0;
        end else begin
            if (mem_stall) begin
                wb_rf_w_ena <= 1'b0;
            end else begin
                wb_rf_w_ena <= mem_valid & mem_rf_w_ena & (mem_rf_waddr != 5'd0) & ~w_timeout_hit;
                wb_rf_waddr <= mem_rf_waddr;
                wb_rf_wdata <= w_wb_data;
                if (mem_valid)
                    retired_cnt <= retired_cnt + 32'd1;
            end
            if (w_timeout_hit)
                dm_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios plus randomized ops
// checked against a per-op latency/write-back model.
module tb_mem_wb_stage;

    localparam int unsigned LAT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid, mem_lw, mem_jal, mem_mul, mem_dm_w_ena, mem_rf_w_ena;
    logic [4:0]  mem_rf_waddr;
    logic [31:0] mem_npc, mem_aluc, mem_mul_res, mem_dm_wdata;
    logic        dm_req, dm_we, dm_ack, mem_stall;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        wb_rf_w_ena, dm_timeout;
    logic [4:0]  wb_rf_waddr;
    logic [31:0] wb_rf_wdata, retired_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state
    logic [31:0] m_retired;
    logic        m_timeout;

    // Observations of the last driven op
    int          o_stalls;
    logic        o_req_first, o_we_first, o_stall_first;
    logic [31:0] o_wd_first, o_rdata;
    bit          o_bubble_bad, o_addr_bad, o_hung;

    mem_wb_stage #(.DM_LAT_MAX(LAT)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_npc(mem_npc), .mem_aluc(mem_aluc),
        .mem_mul_res(mem_mul_res), .mem_dm_wdata(mem_dm_wdata),
        .mem_lw(mem_lw), .mem_jal(mem_jal), .mem_mul(mem_mul),
        .mem_dm_w_ena(mem_dm_w_ena), .mem_rf_w_ena(mem_rf_w_ena),
        .mem_rf_waddr(mem_rf_waddr),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack), .mem_stall(mem_stall),
        .wb_rf_w_ena(wb_rf_w_ena), .wb_rf_waddr(wb_rf_waddr), .wb_rf_wdata(wb_rf_wdata),
        .dm_timeout(dm_timeout), .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    // An op that reaches ack after d wait cycles stalls d cycles, capped by the timeout window.
    function automatic int exp_stalls(input logic memop, input int d);
        if (!memop) return 0;
        return (d < int'(LAT) - 1) ? d : int'(LAT) - 1;
    endfunction

    function automatic logic exp_timed_out(input logic memop, input int d);
        return memop && (d >= int'(LAT));
    endfunction

    function automatic logic [31:0] exp_wdata(input logic lw, jal, mul,
                                              input logic [31:0] rdata, npc, mulr, aluc);
        if (lw)  return rdata;
        if (jal) return npc;
        if (mul) return mulr;
        return aluc;
    endfunction

    task automatic idle_inputs();
        mem_valid = 0; mem_lw = 0; mem_jal = 0; mem_mul = 0; mem_dm_w_ena = 0;
        mem_rf_w_ena = 0; mem_rf_waddr = 0; mem_npc = 0; mem_aluc = 0;
        mem_mul_res = 0; mem_dm_wdata = 0; dm_ack = 0; dm_rdata = 0;
    endtask

    // Presents one op (called just after a rising edge); ack arrives in wait cycle d.
    task automatic drive_op(input logic v, lw, jal, mul, st, rfwe, input logic [4:0] wa,
                            input logic [31:0] npc, aluc, mulr, wd,
                            input int d, input logic [31:0] rdata);
        logic stalled;
        mem_valid = v; mem_lw = lw; mem_jal = jal; mem_mul = mul; mem_dm_w_ena = st;
        mem_rf_w_ena = rfwe; mem_rf_waddr = wa; mem_npc = npc; mem_aluc = aluc;
        mem_mul_res = mulr; mem_dm_wdata = wd;
        o_stalls = 0; o_bubble_bad = 0; o_addr_bad = 0; o_hung = 1;
        for (int cyc = 0; cyc < 64; cyc++) begin
            dm_ack   = (cyc == d);
            dm_rdata = (cyc == d) ? rdata : $urandom;
            o_rdata  = dm_rdata;
            #2;
            if (cyc == 0) begin
                o_req_first = dm_req; o_we_first = dm_we;
                o_wd_first = dm_wdata; o_stall_first = mem_stall;
            end
            if (dm_req && dm_addr !== aluc) o_addr_bad = 1;
            stalled = mem_stall;
            @(posedge clk); #1;
            if (!stalled) begin
                o_hung = 0;
                break;
            end
            o_stalls++;
            if (wb_rf_w_ena !== 1'b0) o_bubble_bad = 1;
        end
        idle_inputs();
        if (v) m_retired = m_retired + 32'd1;
        if (exp_timed_out(v & (lw | st), d)) m_timeout = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1;
        idle_inputs();
        mem_valid = 1; mem_lw = 1; mem_rf_w_ena = 1; mem_rf_waddr = 5'd3;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (dm_req !== 1'b0 || mem_stall !== 1'b0) begin
            n_fail++; $display("FAIL reset_comb: req=%b stall=%b want 0 0", dm_req, mem_stall);
        end
        n_tests++;
        if (wb_rf_w_ena !== 1'b0 || wb_rf_waddr !== 5'd0 || wb_rf_wdata !== 32'd0) begin
            n_fail++; $display("FAIL reset_wb: ena=%b addr=%0d data=%h want 0 0 0",
                               wb_rf_w_ena, wb_rf_waddr, wb_rf_wdata);
        end
        n_tests++;
        if (dm_timeout !== 1'b0 || retired_cnt !== 32'd0) begin
            n_fail++; $display("FAIL reset_status: timeout=%b retired=%0d want 0 0", dm_timeout, retired_cnt);
        end
        idle_inputs();
        rst = 0;
        m_retired = 0; m_timeout = 0;
    endtask

    task automatic test_alu();
        drive_op(1, 0, 0, 0, 0, 1, 5'd5, 32'h0, 32'h12345678, 32'h0, 32'h0, 1000, 32'h0);
        n_tests++;
        if (o_stall_first !== 1'b0 || o_req_first !== 1'b0 || o_stalls != 0) begin
            n_fail++; $display("FAIL alu_nostall: stall=%b req=%b stalls=%0d want 0 0 0",
                               o_stall_first, o_req_first, o_stalls);
        end
        n_tests++;
        if (wb_rf_w_ena !== 1'b1 || wb_rf_waddr !== 5'd5 || wb_rf_wdata !== 32'h12345678) begin
            n_fail++; $display("FAIL alu_wb: ena=%b addr=%0d data=%h want 1 5 12345678",
                               wb_rf_w_ena, wb_rf_waddr, wb_rf_wdata);
        end
    endtask

    task automatic test_load_wait();
        drive_op(1, 1, 0, 0, 0, 1, 5'd8, 32'h0, 32'h00001000, 32'h0, 32'h0, 3, 32'hDEADBEEF);
        n_tests++;
        if (o_stalls != 3 || o_bubble_bad || o_addr_bad || !o_req_first) begin
            n_fail++; $display("FAIL load_wait: stalls=%0d bubble_bad=%0b addr_bad=%0b req=%b want 3 0 0 1",
                               o_stalls, o_bubble_bad, o_addr_bad, o_req_first);
        end
        n_tests++;
        if (wb_rf_w_ena !== 1'b1 || wb_rf_waddr !== 5'd8 || wb_rf_wdata !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL load_wb: ena=%b addr=%0d data=%h want 1 8 deadbeef",
                               wb_rf_w_ena, wb_rf_waddr, wb_rf_wdata);
        end
        n_tests++;
        if (retired_cnt !== m_retired) begin
            n_fail++; $display("FAIL load_retired: got %0d want %0d", retired_cnt, m_retired);
        end
    endtask

    task automatic test_store_back_to_back();
        drive_op(1, 0, 0, 0, 1, 0, 5'd9, 32'h0, 32'h00002000, 32'h0, 32'hCAFEF00D, 0, 32'h0);
        n_tests++;
        if (!o_req_first || !o_we_first || o_stall_first || o_wd_first !== 32'hCAFEF00D || o_stalls != 0) begin
            n_fail++; $display("FAIL store_issue: req=%b we=%b stall=%b wd=%h stalls=%0d want 1 1 0 cafef00d 0",
                               o_req_first, o_we_first, o_stall_first, o_wd_first, o_stalls);
        end
        n_tests++;
        if (wb_rf_w_ena !== 1'b0) begin
            n_fail++; $display("FAIL store_nowrite: ena=%b want 0", wb_rf_w_ena);
        end
        drive_op(1, 1, 0, 0, 0, 1, 5'd10, 32'h0, 32'h00002004, 32'h0, 32'h0, 2, 32'h0BADF00D);
        n_tests++;
        if (!o_req_first || o_stalls != 2 || wb_rf_wdata !== 32'h0BADF00D || wb_rf_w_ena !== 1'b1) begin
            n_fail++; $display("FAIL b2b_load: req=%b stalls=%0d data=%h ena=%b want 1 2 0badf00d 1",
                               o_req_first, o_stalls, wb_rf_wdata, wb_rf_w_ena);
        end
    endtask

    task automatic test_timeout();
        n_tests++;
        if (dm_timeout !== 1'b0) begin
            n_fail++; $display("FAIL timeout_pre: got %b want 0", dm_timeout);
        end
        drive_op(1, 1, 0, 0, 0, 1, 5'd11, 32'h0, 32'h00003000, 32'h0, 32'h0, 1000, 32'h0);
        n_tests++;
        if (o_hung || o_stalls != exp_stalls(1'b1, 1000)) begin
            n_fail++; $display("FAIL timeout_stalls: hung=%0b stalls=%0d want 0 %0d",
                               o_hung, o_stalls, exp_stalls(1'b1, 1000));
        end
        n_tests++;
        if (dm_timeout !== 1'b1 || wb_rf_w_ena !== 1'b0 || retired_cnt !== m_retired) begin
            n_fail++; $display("FAIL timeout_result: flag=%b ena=%b retired=%0d want 1 0 %0d",
                               dm_timeout, wb_rf_w_ena, retired_cnt, m_retired);
        end
    endtask

    task automatic test_priority_x0();
        drive_op(1, 0, 1, 1, 0, 1, 5'd12, 32'h40, 32'h77, 32'h99, 32'h0, 1000, 32'h0);
        n_tests++;
        if (wb_rf_w_ena !== 1'b1 || wb_rf_wdata !== 32'h40) begin
            n_fail++; $display("FAIL prio_jal: ena=%b data=%h want 1 00000040", wb_rf_w_ena, wb_rf_wdata);
        end
        drive_op(1, 0, 0, 1, 0, 1, 5'd0, 32'h40, 32'h77, 32'h99, 32'h0, 1000, 32'h0);
        n_tests++;
        if (wb_rf_w_ena !== 1'b0 || wb_rf_wdata !== 32'h99) begin
            n_fail++; $display("FAIL x0_write: ena=%b data=%h want 0 00000099", wb_rf_w_ena, wb_rf_wdata);
        end
    endtask

    task automatic test_bubble();
        drive_op(0, 1, 0, 0, 1, 1, 5'd13, 32'h0, 32'h5000, 32'h0, 32'h0, 1000, 32'h0);
        n_tests++;
        if (o_req_first || o_stall_first || wb_rf_w_ena !== 1'b0 || retired_cnt !== m_retired) begin
            n_fail++; $display("FAIL bubble: req=%b stall=%b ena=%b retired=%0d want 0 0 0 %0d",
                               o_req_first, o_stall_first, wb_rf_w_ena, retired_cnt, m_retired);
        end
    endtask

    task automatic test_random();
        logic v, lw, jal, mul, st, rfwe, memop, e_ena;
        logic [4:0] wa;
        logic [31:0] npc, aluc, mulr, wd, rd, e_data;
        int d;
        for (int i = 0; i < 40; i++) begin
            v = ($urandom_range(0, 3) != 0);
            lw = $urandom_range(0, 1); jal = $urandom_range(0, 1);
            mul = $urandom_range(0, 1); st = lw ? 1'b0 : 1'($urandom_range(0, 1));
            rfwe = $urandom_range(0, 1); wa = 5'($urandom);
            npc = $urandom; aluc = $urandom; mulr = $urandom; wd = $urandom; rd = $urandom;
            d = $urandom_range(0, 9);
            memop = v & (lw | st);
            drive_op(v, lw, jal, mul, st, rfwe, wa, npc, aluc, mulr, wd, d, rd);
            e_ena  = v & rfwe & (wa != 5'd0) & ~exp_timed_out(memop, d);
            e_data = exp_wdata(lw, jal, mul, o_rdata, npc, mulr, aluc);
            n_tests++;
            if (o_hung || o_stalls != exp_stalls(memop, d) || o_bubble_bad || o_addr_bad
                || o_req_first !== memop) begin
                n_fail++; $display("FAIL rand_timing[%0d]: stalls=%0d req=%b bubble_bad=%0b addr_bad=%0b want %0d %b 0 0",
                                   i, o_stalls, o_req_first, o_bubble_bad, o_addr_bad,
                                   exp_stalls(memop, d), memop);
            end
            n_tests++;
            if (wb_rf_w_ena !== e_ena || wb_rf_waddr !== wa || wb_rf_wdata !== e_data) begin
                n_fail++; $display("FAIL rand_wb[%0d]: ena=%b addr=%0d data=%h want %b %0d %h",
                                   i, wb_rf_w_ena, wb_rf_waddr, wb_rf_wdata, e_ena, wa, e_data);
            end
            n_tests++;
            if (retired_cnt !== m_retired || dm_timeout !== m_timeout) begin
                n_fail++; $display("FAIL rand_status[%0d]: retired=%0d timeout=%b want %0d %b",
                                   i, retired_cnt, dm_timeout, m_retired, m_timeout);
            end
        end
    endtask

    task automatic test_reset_mid_access();
        idle_inputs();
        mem_valid = 1; mem_lw = 1; mem_rf_w_ena = 1; mem_rf_waddr = 5'd14; mem_aluc = 32'h6000;
        @(posedge clk); #1;
        n_tests++;
        if (dm_req !== 1'b1 || mem_stall !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_pre: req=%b stall=%b want 1 1", dm_req, mem_stall);
        end
        #2 rst = 1;
        #1;
        n_tests++;
        if (dm_req !== 1'b0 || mem_stall !== 1'b0 || dm_we !== 1'b0 || dm_addr !== 32'd0) begin
            n_fail++; $display("FAIL rstmid_comb: req=%b stall=%b we=%b addr=%h want 0 0 0 0",
                               dm_req, mem_stall, dm_we, dm_addr);
        end
        n_tests++;
        if (wb_rf_w_ena !== 1'b0 || wb_rf_waddr !== 5'd0 || wb_rf_wdata !== 32'd0
            || dm_timeout !== 1'b0 || retired_cnt !== 32'd0) begin
            n_fail++; $display("FAIL rstmid_regs: ena=%b addr=%0d data=%h timeout=%b retired=%0d want 0 0 0 0 0",
                               wb_rf_w_ena, wb_rf_waddr, wb_rf_wdata, dm_timeout, retired_cnt);
        end
        @(posedge clk); #1;
        idle_inputs();
        rst = 0;
        m_retired = 0; m_timeout = 0;
        drive_op(1, 1, 0, 0, 0, 1, 5'd15, 32'h0, 32'h7000, 32'h0, 32'h0, 1, 32'h13579BDF);
        n_tests++;
        if (o_stalls != 1 || wb_rf_w_ena !== 1'b1 || wb_rf_waddr !== 5'd15
            || wb_rf_wdata !== 32'h13579BDF || retired_cnt !== 32'd1) begin
            n_fail++; $display("FAIL rstmid_after: stalls=%0d ena=%b addr=%0d data=%h retired=%0d want 1 1 15 13579bdf 1",
                               o_stalls, wb_rf_w_ena, wb_rf_waddr, wb_rf_wdata, retired_cnt);
        end
    endtask

    initial begin
        m_retired = 0;
        m_timeout = 0;
        test_reset();
        test_alu();
        test_load_wait();
        test_store_back_to_back();
        test_timeout();
        test_priority_x0();
        test_bubble();
        test_random();
        test_reset_mid_access();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
